// File: rtl/key_debounce_pkg.sv
// Shared FSM state encoding and width helper for the key debouncer.
// Optional long-press strobe is enabled by defining KEY_LONGPRESS_EN.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    KEY_ST_RELEASED    = 2'd0,
    KEY_ST_CHK_PRESS   = 2'd1,
    KEY_ST_PRESSED     = 2'd2,
    KEY_ST_CHK_RELEASE = 2'd3
  } key_st_t;

  // Bits needed to hold 0..v-1; never less than 1 so a terminal count of 0 still has a register.
  function automatic int clog2(input int v);
    int w;
    w = 0;
    while ((1 << w) < v) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key: 2-flop synchronizer, debounce FSM, press/release (and optional KEY_LONGPRESS_EN long) strobes.
// Latency DEBOUNCE_CYCLES+3 edges from pin change to registered strobe; no backpressure, strobes are one-shot.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int KEY_ACTIVE_LOW  = 1,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int            CW       = clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic          IDLE_LVL = (KEY_ACTIVE_LOW != 0);

  logic [1:0]    sync;
  logic          pressed_s;
  key_st_t       state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          key_state_nx, key_press_nx, key_release_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= {IDLE_LVL, IDLE_LVL};
    else        sync <= {sync[0], key_in};
  end

  assign pressed_s = sync[1] ^ IDLE_LVL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= KEY_ST_RELEASED;
      cnt         <= '0;
      key_state   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      key_state   <= key_state_nx;
      key_press   <= key_press_nx;
      key_release <= key_release_nx;
    end
  end

  // Terminal count forces a state change, so cnt can never wrap.
  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    key_state_nx   = key_state;
    key_press_nx   = 1'b0;
    key_release_nx = 1'b0;
    case (state)
      KEY_ST_RELEASED: begin
        if (pressed_s) begin
          state_nx = KEY_ST_CHK_PRESS;
          cnt_nx   = '0;
        end
      end
      KEY_ST_CHK_PRESS: begin
        if (!pressed_s) begin
          state_nx = KEY_ST_RELEASED;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx     = KEY_ST_PRESSED;
          key_state_nx = 1'b1;
          key_press_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      KEY_ST_PRESSED: begin
        if (!pressed_s) begin
          state_nx = KEY_ST_CHK_RELEASE;
          cnt_nx   = '0;
        end
      end
      KEY_ST_CHK_RELEASE: begin
        if (pressed_s) begin
          state_nx = KEY_ST_PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_nx       = KEY_ST_RELEASED;
          key_state_nx   = 1'b0;
          key_release_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = KEY_ST_RELEASED;
        cnt_nx   = '0;
      end
    endcase
  end

`ifdef KEY_LONGPRESS_EN
  localparam int            HW        = clog2(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  logic [HW-1:0] hold;
  logic          long_done;

  // Hold time keeps running through release bounce; long_done limits it to one strobe per press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold      <= '0;
      long_done <= 1'b0;
      key_long  <= 1'b0;
    end else if (state == KEY_ST_CHK_PRESS && state_nx == KEY_ST_PRESSED) begin
      hold      <= '0;
      long_done <= 1'b0;
      key_long  <= 1'b0;
    end else if (state == KEY_ST_PRESSED || state == KEY_ST_CHK_RELEASE) begin
      key_long <= (hold == HOLD_LAST) && !long_done;
      if (hold == HOLD_LAST) long_done <= 1'b1;
      else                   hold      <= hold + HW'(1);
    end else begin
      hold      <= '0;
      long_done <= 1'b0;
      key_long  <= 1'b0;
    end
  end
`else
  assign key_long = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Multi-channel key conditioner: KEY_NUM independent debounce channels (long-press via KEY_LONGPRESS_EN).
// Latency DEBOUNCE_CYCLES+3 edges per channel; no backpressure, all outputs registered strobes/levels.
module key_debounce #(
  parameter int KEY_NUM         = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int KEY_ACTIVE_LOW  = 1,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long
);

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_in     (key_in[i]),
      .key_state  (key_state[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_long   (key_long[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench: stimulus queues expected strobe events, a monitor pops one per observed strobe cycle.
module tb_key_debounce;

  localparam int N    = 4;
  localparam int DEB  = 8;
  localparam int LONG = 32;
  localparam int LAT  = DEB + 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] key_in = '1;
  logic [N-1:0] key_state, key_press, key_release, key_long;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    int           cyc;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] lng;
    logic [N-1:0] state;
  } ev_t;

  ev_t exp_q[$];

  key_debounce #(
    .KEY_NUM(N), .DEBOUNCE_CYCLES(DEB), .KEY_ACTIVE_LOW(1), .LONG_CYCLES(LONG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in),
    .key_state(key_state), .key_press(key_press),
    .key_release(key_release), .key_long(key_long)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void push_ev(int c, logic [N-1:0] p, logic [N-1:0] r,
                                  logic [N-1:0] l, logic [N-1:0] s);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.lng = l; e.state = s;
    exp_q.push_back(e);
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every strobe cycle must match the oldest expected event.
  always @(negedge clk) begin
    ev_t e;
    if (rst_n && (|key_press || |key_release || |key_long)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", int'({key_press, key_release, key_long}), 0);
      end else begin
        e = exp_q.pop_front();
        check("ev_cycle",   cyc,              e.cyc);
        check("ev_press",   int'(key_press),   int'(e.press));
        check("ev_release", int'(key_release), int'(e.rel));
        check("ev_long",    int'(key_long),    int'(e.lng));
        check("ev_state",   int'(key_state),   int'(e.state));
      end
    end
  end

  task automatic check_all_zero(input string nm);
    check({nm, "_state"},   int'(key_state),   0);
    check({nm, "_press"},   int'(key_press),   0);
    check({nm, "_release"}, int'(key_release), 0);
    check({nm, "_long"},    int'(key_long),    0);
  endtask

  initial begin
    // Reset
    wait_cyc(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    wait_cyc(5);
    check_all_zero("idle");

    // Clean press on key 0, held long enough to cover the long-press window
    key_in[0] = 1'b0;
    push_ev(cyc + LAT, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
`ifdef KEY_LONGPRESS_EN
    push_ev(cyc + LAT + LONG, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
`endif
    wait_cyc(100);
    check("press0_state", int'(key_state), 1);

    // Bounce on key 1: never stable for DEB cycles
    for (int i = 0; i < 4; i++) begin
      key_in[1] = 1'b0; wait_cyc(5);
      key_in[1] = 1'b1; wait_cyc(3);
    end
    wait_cyc(20);
    check("bounce1_state", int'(key_state), 1);

    // Release of key 0 with bounce; release counts from the final rising edge
    key_in[0] = 1'b1; wait_cyc(4);
    key_in[0] = 1'b0; wait_cyc(2);
    key_in[0] = 1'b1;
    push_ev(cyc + LAT, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    wait_cyc(20);
    check("release0_state", int'(key_state), 0);

    // Simultaneous press and release on keys 2 and 3
    key_in[3:2] = 2'b00;
    push_ev(cyc + LAT, 4'b1100, 4'b0000, 4'b0000, 4'b1100);
    wait_cyc(20);
    check("press23_state", int'(key_state), 12);
    key_in[3:2] = 2'b11;
    push_ev(cyc + LAT, 4'b0000, 4'b1100, 4'b0000, 4'b0000);
    wait_cyc(20);

    // Reset in the middle of CHK_PRESS with key 0 held
    key_in[0] = 1'b0;
    wait_cyc(6);
    rst_n = 1'b0;
    wait_cyc(1);
    check_all_zero("midreset");
    wait_cyc(3);
    check_all_zero("midreset_hold");
    rst_n = 1'b1;
    push_ev(cyc + LAT, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
`ifdef KEY_LONGPRESS_EN
    push_ev(cyc + LAT + LONG, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
`endif
    wait_cyc(60);
    key_in[0] = 1'b1;
    push_ev(cyc + LAT, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    wait_cyc(30);

    check("final_state", int'(key_state), 0);
    check("pending_events", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
Multi-channel push-button input conditioner. It is the input-side counterpart of the board LED driver: raw, bouncing, asynchronous key pins come in, and clean per-key level, press and release strobes go out. It sits between the board key pins and the user logic in the clk domain, one instance per board.

Parameters:
KEY_NUM, 4, number of independent key channels
DEBOUNCE_CYCLES, 1000000, stable-level qualification time in clk cycles (20 ms at 50 MHz); must be >= 1
KEY_ACTIVE_LOW, 1, 1 = a pressed key reads 0 on the pin (pull-up); 0 = a pressed key reads 1
LONG_CYCLES, 50000000, long-press threshold in clk cycles, counted from the key_press pulse (optional feature only)

Ports:
clk  input  1  system clock; single clock domain
rst_n  input  1  asynchronous active-low reset
key_in  input  KEY_NUM  raw key pins, asynchronous to clk
key_state  output  KEY_NUM  debounced level, 1 = pressed
key_press  output  KEY_NUM  one-cycle strobe on a qualified press
key_release  output  KEY_NUM  one-cycle strobe on a qualified release
key_long  output  KEY_NUM  one-cycle long-press strobe; tied to 0 when the feature is off

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low. All outputs are registered.
- Reset values: key_state, key_press, key_release and key_long are 0. Synchronizer flops reset to the released pin level (1 when KEY_ACTIVE_LOW=1). FSM is RELEASED. All counters are 0.
- Synchronizer: 2-flop synchronizer per channel. Normalised level: pressed_s = KEY_ACTIVE_LOW ? ~sync : sync.
- Channels are fully independent; simultaneous events on different keys produce strobes in the same cycle.
- Per-channel FSM states (2-bit encoding) and per-channel counter cnt, width clog2(DEBOUNCE_CYCLES):
  RELEASED: if pressed_s, go to CHK_PRESS with cnt=0.
  CHK_PRESS: if !pressed_s, go to RELEASED and clear cnt. Else if cnt==DEBOUNCE_CYCLES-1, go to PRESSED, set key_state=1 and pulse key_press. Else cnt++.
  PRESSED: if !pressed_s, go to CHK_RELEASE with cnt=0.
  CHK_RELEASE: if pressed_s, return to PRESSED (no strobe). Else if cnt==DEBOUNCE_CYCLES-1, go to RELEASED, set key_state=0 and pulse key_release. Else cnt++.
- Latency: for a raw level change held stable, the strobe is high in the cycle after clock edge DEBOUNCE_CYCLES+3, counting the first edge that samples the new pin level as edge 1. key_state changes on the same edge. The strobe is exactly 1 cycle wide.
- Glitch rule: any excursion shorter than DEBOUNCE_CYCLES consecutive synchronized cycles produces no strobe and no change to key_state.
- Counters never wrap; they saturate by design because of the state transition at the terminal count.
- Reset mid-operation: asserting rst_n clears the channel immediately, including in CHK_* states. No strobe is emitted on exit from reset, even if a key is held. A key held through reset is qualified afresh and yields key_press DEBOUNCE_CYCLES+3 edges after rst_n deasserts.

Optional Feature:
Macro KEY_LONGPRESS_EN.
- Defined: adds a per-channel hold counter, width clog2(LONG_CYCLES).
  - Cleared on entry to PRESSED from CHK_PRESS.
  - Increments in PRESSED and CHK_RELEASE, so release bounce does not restart it.
  - Cleared in RELEASED.
  - At the edge where it reaches LONG_CYCLES-1, key_long pulses for 1 cycle, i.e. LONG_CYCLES cycles after key_press.
  - At most one key_long per press; no auto-repeat.
- Undefined: no hold counter is synthesized; key_long is constant 0.

Decomposition:
- The shared macro header holds the FSM state encodings (KEY_ST_RELEASED=0, KEY_ST_CHK_PRESS=1, KEY_ST_PRESSED=2, KEY_ST_CHK_RELEASE=3), a clog2 constant function, and the KEY_LONGPRESS_EN switch.
- One sub-module, key_debounce_ch: synchronizer, FSM, counters and strobes for a single key.
- The top level instantiates key_debounce_ch KEY_NUM times via generate.

Test Plan:
- Sim parameters: DEBOUNCE_CYCLES=8, LONG_CYCLES=32, KEY_ACTIVE_LOW=1.
- Clean press: key_in[0] 1->0, held -> key_press[0] high for exactly 1 cycle after edge 11; key_state[0]=1 from then on; other channels stay 0.
- Bounce: key_in[1] low for 5 cycles, high for 3, repeated 4 times, then high -> no key_press[1], key_state[1] stays 0.
- Release with bounce: key 0 pressed, then 1 for 4 cycles, 0 for 2, then 1 held -> exactly one key_release[0], 11 edges after the final rising edge; key_state[0]=0.
- Simultaneous: key_in[2] and key_in[3] fall on the same edge -> key_press[2] and key_press[3] in the same cycle.
- Reset: key_in[0]=0 held while rst_n is pulsed low mid-CHK_PRESS -> all outputs 0 during reset; key_press[0] fires 11 edges after rst_n rises.
- Long press (KEY_LONGPRESS_EN defined): hold key_in[0]=0 for 100 cycles -> key_long[0] one pulse 32 cycles after key_press[0], no second pulse. Macro undefined -> key_long stays 0.
